// File: rtl/mem_arbiter_2x1.sv
// Two-port round-robin arbiter sharing one single-ported cache memory.
// One operation in flight; memory command and responses come from registered state.
module mem_arbiter_2x1 #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_v,
    output logic            req0_ready,
    input  logic            req0_we,
    input  logic [31:0]     req0_adr,
    input  logic [XLEN-1:0] req0_data,
    input  logic [3:0]      req0_strobe,
    output logic            rsp0_v,
    output logic [XLEN-1:0] rsp0_data,
    output logic            rsp0_err,
    input  logic            req1_v,
    output logic            req1_ready,
    input  logic            req1_we,
    input  logic [31:0]     req1_adr,
    input  logic [XLEN-1:0] req1_data,
    input  logic [3:0]      req1_strobe,
    output logic            rsp1_v,
    output logic [XLEN-1:0] rsp1_data,
    output logic            rsp1_err,
    output logic            mem_r_v,
    output logic            mem_w_v,
    output logic [31:0]     mem_adr,
    output logic [XLEN-1:0] mem_data,
    output logic [3:0]      mem_strobe,
    input  logic [XLEN-1:0] mem_resp,
    input  logic            mem_resp_valid,
    input  logic            mem_resp_error
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    state_t            state, state_d;
    logic              last_grant;
    logic              port_q, we_q, err_q;
    logic [31:0]       adr_q;
    logic [XLEN-1:0]   data_q, rdata_q;
    logic [3:0]        strb_q;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   hold0_data, hold1_data;
    logic              hold0_err, hold1_err;
    logic              grant1, hs0, hs1;

    always_comb begin
        grant1     = req1_v && (!req0_v || !last_grant);
        req0_ready = (state == IDLE) && req0_v && !grant1;
        req1_ready = (state == IDLE) && grant1;
        hs0        = req0_v && req0_ready;
        hs1        = req1_v && req1_ready;

        state_d = state;
        case (state)
            IDLE:    if (hs0 || hs1) state_d = ISSUE;
            ISSUE:   state_d = we_q ? RESP : WAIT_RD;
            WAIT_RD: if (mem_resp_valid || cnt == CNT_MAX) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            adr_q      <= '0;
            data_q     <= '0;
            rdata_q    <= '0;
            strb_q     <= '0;
            cnt        <= '0;
            hold0_data <= '0;
            hold1_data <= '0;
            hold0_err  <= 1'b0;
            hold1_err  <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: if (hs0 || hs1) begin
                    port_q     <= hs1;
                    last_grant <= hs1;
                    we_q       <= hs1 ? req1_we     : req0_we;
                    adr_q      <= hs1 ? req1_adr    : req0_adr;
                    data_q     <= hs1 ? req1_data   : req0_data;
                    strb_q     <= hs1 ? req1_strobe : req0_strobe;
                end
                ISSUE: begin
                    err_q   <= mem_resp_error;
                    cnt     <= '0;
                    rdata_q <= '0;
                end
                WAIT_RD: begin
                    if (mem_resp_valid) begin
                        rdata_q <= mem_resp;
                    end else if (cnt == CNT_MAX) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (port_q) begin
                        hold1_data <= rdata_q;
                        hold1_err  <= err_q;
                    end else begin
                        hold0_data <= rdata_q;
                        hold0_err  <= err_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Response fields show the live result during RESP and keep it afterwards.
    always_comb begin
        rsp0_v     = (state == RESP) && !port_q;
        rsp1_v     = (state == RESP) && port_q;
        rsp0_data  = rsp0_v ? rdata_q : hold0_data;
        rsp0_err   = rsp0_v ? err_q   : hold0_err;
        rsp1_data  = rsp1_v ? rdata_q : hold1_data;
        rsp1_err   = rsp1_v ? err_q   : hold1_err;
        mem_r_v    = (state == ISSUE) && !we_q;
        mem_w_v    = (state == ISSUE) && we_q;
        mem_adr    = adr_q;
        mem_data   = data_q;
        mem_strobe = strb_q;
    end
endmodule

// File: tb/tb_mem_arbiter_2x1.sv
// Directed bench for mem_arbiter_2x1 with a small word memory model behind it.
module tb_mem_arbiter_2x1;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned TIMEOUT = 15;
    localparam logic [31:0] BASE    = 32'h4E20;
    localparam logic [31:0] LIMIT   = 32'h5220;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_v = 0, req0_we = 0, req1_v = 0, req1_we = 0;
    logic [31:0] req0_adr = '0, req1_adr = '0;
    logic [XLEN-1:0] req0_data = '0, req1_data = '0;
    logic [3:0] req0_strobe = '0, req1_strobe = '0;
    logic req0_ready, req1_ready, rsp0_v, rsp1_v, rsp0_err, rsp1_err;
    logic [XLEN-1:0] rsp0_data, rsp1_data;
    logic mem_r_v, mem_w_v;
    logic [31:0] mem_adr;
    logic [XLEN-1:0] mem_data;
    logic [3:0] mem_strobe;
    logic [XLEN-1:0] mem_resp = '0;
    logic mem_resp_valid = 1'b0;
    logic mem_resp_error;

    int checks = 0;
    int errors = 0;

    mem_arbiter_2x1 #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0_v(req0_v), .req0_ready(req0_ready), .req0_we(req0_we), .req0_adr(req0_adr),
        .req0_data(req0_data), .req0_strobe(req0_strobe),
        .rsp0_v(rsp0_v), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .req1_v(req1_v), .req1_ready(req1_ready), .req1_we(req1_we), .req1_adr(req1_adr),
        .req1_data(req1_data), .req1_strobe(req1_strobe),
        .rsp1_v(rsp1_v), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .mem_r_v(mem_r_v), .mem_w_v(mem_w_v), .mem_adr(mem_adr), .mem_data(mem_data),
        .mem_strobe(mem_strobe), .mem_resp(mem_resp), .mem_resp_valid(mem_resp_valid),
        .mem_resp_error(mem_resp_error)
    );

    always #5 clk = ~clk;

    // Memory model: range error is combinational on the command, read data follows after resp_delay cycles.
    logic [31:0] mem [0:255];
    int          resp_delay = 1;
    logic        resp_en = 1'b1;
    int          pend = 0;
    logic [31:0] pdata = '0;

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE) && (a < LIMIT);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off[9:2]);
    endfunction

    assign mem_resp_error = (mem_r_v || mem_w_v) && !in_range(mem_adr);

    always @(negedge clk) begin
        mem_resp_valid = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp = pdata;
            end
        end
        if (mem_w_v && !mem_resp_error) begin
            for (int b = 0; b < 4; b++)
                if (mem_strobe[b]) mem[widx(mem_adr)][b*8 +: 8] = mem_data[b*8 +: 8];
        end
        if (mem_r_v && resp_en) begin
            pend  = resp_delay;
            pdata = in_range(mem_adr) ? mem[widx(mem_adr)] : 32'h0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic port, input logic v, input logic we, input logic [31:0] adr,
                         input logic [31:0] data, input logic [3:0] strb);
        if (port) begin
            req1_v = v; req1_we = we; req1_adr = adr; req1_data = data; req1_strobe = strb;
        end else begin
            req0_v = v; req0_we = we; req0_adr = adr; req0_data = data; req0_strobe = strb;
        end
    endtask

    // Request, wait for grant, then follow the op until its response pulse.
    task automatic run_txn(input string name, input logic port, input logic we, input logic [31:0] adr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        logic granted;
        logic got;
        int   lat;
        granted = 1'b0;
        got = 1'b0;
        lat = 0;
        @(negedge clk);
        drive(port, 1'b1, we, adr, data, strb);
        for (int i = 0; i < 20 && !granted; i++) begin
            #1;
            if (port ? req1_ready : req0_ready) granted = 1'b1;
            else @(negedge clk);
        end
        chk({name, "_grant"}, {31'b0, granted}, 32'd1);
        if (!granted) begin
            drive(port, 1'b0, we, adr, data, strb);
            return;
        end
        @(posedge clk);
        #1 drive(port, 1'b0, we, adr, data, strb);
        for (int i = 0; i < int'(TIMEOUT) + 10 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk({name, "_cmd_rw"}, {30'b0, mem_r_v, mem_w_v}, {30'b0, !we, we});
                chk({name, "_cmd_adr"}, mem_adr, adr);
                chk({name, "_cmd_strb"}, {28'b0, mem_strobe}, {28'b0, strb});
                if (we) chk({name, "_cmd_data"}, mem_data, data);
            end else begin
                chk({name, "_cmd_idle"}, {30'b0, mem_r_v, mem_w_v}, 32'd0);
            end
            chk({name, "_other_rsp"}, {31'b0, port ? rsp0_v : rsp1_v}, 32'd0);
            if (port ? rsp1_v : rsp0_v) begin
                got = 1'b1;
                chk({name, "_lat"}, lat, exp_lat);
                chk({name, "_data"}, port ? rsp1_data : rsp0_data, exp_data);
                chk({name, "_err"}, {31'b0, port ? rsp1_err : rsp0_err}, {31'b0, exp_err});
            end
        end
        chk({name, "_rsp_seen"}, {31'b0, got}, 32'd1);
        @(negedge clk);
        chk({name, "_pulse_1cyc"}, {30'b0, rsp0_v, rsp1_v}, 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctrl"}, {24'b0, req0_ready, req1_ready, rsp0_v, rsp1_v, rsp0_err, rsp1_err,
                              mem_r_v, mem_w_v}, 32'd0);
        chk({name, "_rsp0_data"}, rsp0_data, 32'd0);
        chk({name, "_rsp1_data"}, rsp1_data, 32'd0);
        chk({name, "_mem_adr"}, mem_adr, 32'd0);
        chk({name, "_mem_data"}, mem_data, 32'd0);
        chk({name, "_mem_strb"}, {28'b0, mem_strobe}, 32'd0);
    endtask

    typedef struct {
        string       name;
        logic        port;
        logic        we;
        logic [31:0] adr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t vecs[10];
        int   order[6];
        int   n;
        logic saw_late;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'hDEADBEEF;

        vecs[0] = '{"p0_rd",       1'b0, 1'b0, 32'h4E20, 32'h0,        4'b1111, 32'hDEADBEEF, 1'b0, 3};
        vecs[1] = '{"p1_wr",       1'b1, 1'b1, 32'h4E24, 32'h12345678, 4'b0011, 32'h0,        1'b0, 2};
        vecs[2] = '{"p1_rd_strb",  1'b1, 1'b0, 32'h4E24, 32'h0,        4'b1111, 32'h00005678, 1'b0, 3};
        vecs[3] = '{"p0_wr_oob",   1'b0, 1'b1, 32'h5220, 32'h11111111, 4'b1111, 32'h0,        1'b1, 2};
        vecs[4] = '{"p0_rd_oob",   1'b0, 1'b0, 32'h5220, 32'h0,        4'b1111, 32'h0,        1'b1, 3};
        vecs[5] = '{"p1_wr_hi",    1'b1, 1'b1, 32'h4E28, 32'hFFFFFFFF, 4'b1100, 32'h0,        1'b0, 2};
        vecs[6] = '{"p0_rd_hi",    1'b0, 1'b0, 32'h4E28, 32'h0,        4'b1111, 32'hFFFF0000, 1'b0, 3};
        vecs[7] = '{"p0_wr_full",  1'b0, 1'b1, 32'h4E2C, 32'hA5A5A5A5, 4'b1111, 32'h0,        1'b0, 2};
        vecs[8] = '{"p1_rd_full",  1'b1, 1'b0, 32'h4E2C, 32'h0,        4'b1111, 32'hA5A5A5A5, 1'b0, 3};
        vecs[9] = '{"p1_wr_below", 1'b1, 1'b1, 32'h4E1C, 32'h0,        4'b1111, 32'h0,        1'b1, 2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("reset");

        foreach (vecs[i])
            run_txn(vecs[i].name, vecs[i].port, vecs[i].we, vecs[i].adr, vecs[i].data, vecs[i].strb,
                    vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);

        // Round-robin with both ports requesting continuously from reset.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h4E20, 32'h0, 4'b1111);
        drive(1'b1, 1'b1, 1'b0, 32'h4E24, 32'h0, 4'b1111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 100 && n < 6; c++) begin
            #1;
            chk("rr_ready_exclusive", {31'b0, req0_ready && req1_ready}, 32'd0);
            if (req0_ready) begin order[n] = 0; n++; end
            else if (req1_ready) begin order[n] = 1; n++; end
            if (n < 6) @(negedge clk);
        end
        chk("rr_grant_count", n, 6);
        @(posedge clk);
        #1;
        req0_v = 1'b0;
        req1_v = 1'b0;
        for (int i = 0; i < n; i++) chk($sformatf("rr_order_%0d", i), order[i], i % 2);
        repeat (6) @(negedge clk);

        // Read timeout: memory never answers.
        resp_en = 1'b0;
        run_txn("timeout", 1'b0, 1'b0, 32'h4E20, 32'h0, 4'b1111, 32'h0, 1'b1, int'(TIMEOUT) + 3);
        resp_en = 1'b1;
        run_txn("after_timeout", 1'b1, 1'b0, 32'h4E20, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b0, 3);

        // Reset while waiting for read data; the late response must be ignored.
        resp_delay = 4;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h4E20, 32'h0, 4'b1111);
        n = 0;
        for (int i = 0; i < 20 && n == 0; i++) begin
            #1;
            if (req0_ready) n = 1;
            else @(negedge clk);
        end
        chk("rst_grant", n, 1);
        @(posedge clk);
        #1 req0_v = 1'b0;
        @(negedge clk);
        chk("rst_issue", {31'b0, mem_r_v}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("rst_mid");
        saw_late = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_resp_valid) saw_late = 1'b1;
            chk("rst_no_rsp", {30'b0, rsp0_v, rsp1_v}, 32'd0);
        end
        chk("rst_late_valid_driven", {31'b0, saw_late}, 32'd1);
        resp_delay = 1;
        run_txn("after_rst", 1'b1, 1'b0, 32'h4E20, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
